// File: rtl/draw_pkg.sv
// Shared types and constants for the frame-synchronous draw-position scheduler.
package draw_pkg;
  localparam int POS_W     = 12;
  localparam int X_MAX_DEF = 1023;
  localparam int Y_MAX_DEF = 767;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int N_SRC = 2,
  parameter int IW    = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_SRC-1:0] grant,
  output logic [IW-1:0]    idx
);
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && pending[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/draw_pos_sched.sv
// Samples position requests at vblank, grants one per cycle into shadows, then commits all at once.
// Optional build macro DRAW_POS_CLAMP_EN saturates captured coordinates to X_MAX/Y_MAX.
module draw_pos_sched
  import draw_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vblank_start,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*POS_W-1:0] xpos_in,
  input  logic [N_SRC*POS_W-1:0] ypos_in,
  output logic [N_SRC-1:0]       ack,
  output logic [N_SRC*POS_W-1:0] xpos_out,
  output logic [N_SRC*POS_W-1:0] ypos_out,
  output logic                   frame_commit,
  output logic                   busy,
  output logic                   overrun
);
  localparam int IW = $clog2(N_SRC);
  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(Y_MAX);
`ifdef DRAW_POS_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t               state, state_n;
  logic [N_SRC-1:0]     pending;
  logic [IW-1:0]        rr_ptr;
  logic [N_SRC-1:0]     grant;
  logic [IW-1:0]        grant_idx;
  logic [POS_W-1:0]     shadow_x [N_SRC];
  logic [POS_W-1:0]     shadow_y [N_SRC];
  logic [POS_W-1:0]     raw_x, raw_y, cap_x, cap_y;

  rr_pick #(.N_SRC(N_SRC), .IW(IW)) u_pick (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign raw_x = xpos_in[grant_idx*POS_W +: POS_W];
  assign raw_y = ypos_in[grant_idx*POS_W +: POS_W];
  assign cap_x = (CLAMP_EN && raw_x > X_LIM) ? X_LIM : raw_x;
  assign cap_y = (CLAMP_EN && raw_y > Y_LIM) ? Y_LIM : raw_y;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (vblank_start) state_n = (|req) ? SCAN : COMMIT;
      SCAN:    if ((pending & ~grant) == '0) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      rr_ptr       <= '0;
      ack          <= '0;
      xpos_out     <= '0;
      ypos_out     <= '0;
      frame_commit <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < N_SRC; i++) begin
        shadow_x[i] <= '0;
        shadow_y[i] <= '0;
      end
    end else begin
      ack          <= '0;
      frame_commit <= 1'b0;
      busy         <= (state_n != IDLE);
      // A vblank that lands while a frame is still in flight is dropped, not queued.
      if (vblank_start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (vblank_start) pending <= req;
        SCAN: begin
          pending             <= pending & ~grant;
          ack                 <= grant;
          shadow_x[grant_idx] <= cap_x;
          shadow_y[grant_idx] <= cap_y;
        end
        COMMIT: begin
          for (int i = 0; i < N_SRC; i++) begin
            xpos_out[i*POS_W +: POS_W] <= shadow_x[i];
            ypos_out[i*POS_W +: POS_W] <= shadow_y[i];
          end
          frame_commit <= 1'b1;
          rr_ptr       <= (rr_ptr == IW'(N_SRC-1)) ? '0 : rr_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_pos_sched.sv
// Directed vector table plus randomized run against a frame-level reference model.
module tb_draw_pos_sched;
  localparam int N = 2;
  localparam int W = 12;
`ifdef DRAW_POS_CLAMP_EN
  localparam logic [11:0] CX = 12'd1023;
  localparam logic [11:0] CY = 12'd767;
`else
  localparam logic [11:0] CX = 12'd2000;
  localparam logic [11:0] CY = 12'd900;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           vblank_start = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] xpos_in = '0;
  logic [N*W-1:0] ypos_in = '0;
  logic [N-1:0]   ack;
  logic [N*W-1:0] xpos_out, ypos_out;
  logic           frame_commit, busy, overrun;

  int checks = 0;
  int failures = 0;

  draw_pos_sched #(.N_SRC(N)) dut (
    .clk(clk), .rst(rst), .vblank_start(vblank_start), .req(req),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .ack(ack),
    .xpos_out(xpos_out), .ypos_out(ypos_out),
    .frame_commit(frame_commit), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic rst, vb;
    logic [1:0] req;
    logic [11:0] x0, y0, x1, y1;
    logic [1:0] ack;
    logic fc, busy, ovr;
    logic [11:0] ox0, oy0, ox1, oy1;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic r, logic v, logic [1:0] q,
                              logic [11:0] x0, logic [11:0] y0, logic [11:0] x1, logic [11:0] y1,
                              logic [1:0] a, logic fc, logic b, logic ov,
                              logic [11:0] ox0, logic [11:0] oy0, logic [11:0] ox1, logic [11:0] oy1);
    vec_t t;
    t.rst = r; t.vb = v; t.req = q; t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1;
    t.ack = a; t.fc = fc; t.busy = b; t.ovr = ov;
    t.ox0 = ox0; t.oy0 = oy0; t.ox1 = ox1; t.oy1 = oy1;
    return t;
  endfunction

  // Frame-level reference: a grant order list built at the snapshot, then one commit.
  int          m_rr;
  bit          m_busy, m_ovr;
  int          m_q[$];
  logic [11:0] m_sx[N], m_sy[N], m_ox[N], m_oy[N];
  logic [N-1:0] e_ack;
  logic        e_fc;

  function automatic logic [11:0] lim(logic [11:0] v, logic [11:0] mx);
`ifdef DRAW_POS_CLAMP_EN
    return (v > mx) ? mx : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_rr = 0; m_busy = 0; m_ovr = 0; m_q.delete();
    for (int i = 0; i < N; i++) begin
      m_sx[i] = '0; m_sy[i] = '0; m_ox[i] = '0; m_oy[i] = '0;
    end
  endtask

  task automatic model_edge();
    e_ack = '0; e_fc = 1'b0;
    if (rst) model_reset();
    else if (m_busy) begin
      if (vblank_start) m_ovr = 1;
      if (m_q.size() > 0) begin
        int g;
        g = m_q.pop_front();
        m_sx[g] = lim(xpos_in[g*W +: W], 12'd1023);
        m_sy[g] = lim(ypos_in[g*W +: W], 12'd767);
        e_ack[g] = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin m_ox[i] = m_sx[i]; m_oy[i] = m_sy[i]; end
        e_fc = 1'b1;
        m_rr = (m_rr + 1) % N;
        m_busy = 0;
      end
    end else if (vblank_start) begin
      for (int k = 0; k < N; k++)
        if (req[(m_rr + k) % N]) m_q.push_back((m_rr + k) % N);
      m_busy = 1;
    end
  endtask

  initial begin
    logic [N*W-1:0] ex, ey;
    tbl[0]  = mk(1,0,2'b00,   0,  0,  0,  0, 2'b00,0,0,0,   0,  0,  0,  0);
    tbl[1]  = mk(0,0,2'b00,   0,  0,  0,  0, 2'b00,0,0,0,   0,  0,  0,  0);
    tbl[2]  = mk(0,1,2'b11, 100,200,300,400, 2'b00,0,1,0,   0,  0,  0,  0);
    tbl[3]  = mk(0,0,2'b00, 100,200,300,400, 2'b01,0,1,0,   0,  0,  0,  0);
    tbl[4]  = mk(0,0,2'b00, 555,200,300,400, 2'b10,0,1,0,   0,  0,  0,  0);
    tbl[5]  = mk(0,0,2'b00, 555,200,300,400, 2'b00,1,0,0, 100,200,300,400);
    tbl[6]  = mk(0,1,2'b11,  11, 12, 21, 22, 2'b00,0,1,0, 100,200,300,400);
    tbl[7]  = mk(0,0,2'b11,  11, 12, 21, 22, 2'b10,0,1,0, 100,200,300,400);
    tbl[8]  = mk(0,0,2'b11,  11, 12, 21, 22, 2'b01,0,1,0, 100,200,300,400);
    tbl[9]  = mk(0,0,2'b00,  11, 12, 21, 22, 2'b00,1,0,0,  11, 12, 21, 22);
    tbl[10] = mk(0,1,2'b10,  77, 78, 88, 89, 2'b00,0,1,0,  11, 12, 21, 22);
    tbl[11] = mk(0,0,2'b00,  77, 78, 88, 89, 2'b10,0,1,0,  11, 12, 21, 22);
    tbl[12] = mk(0,0,2'b00,  77, 78, 88, 89, 2'b00,1,0,0,  11, 12, 88, 89);
    tbl[13] = mk(0,1,2'b01,   5,  6, 88, 89, 2'b00,0,1,0,  11, 12, 88, 89);
    tbl[14] = mk(0,1,2'b01,   5,  6, 88, 89, 2'b01,0,1,1,  11, 12, 88, 89);
    tbl[15] = mk(0,0,2'b00,   5,  6, 88, 89, 2'b00,1,0,1,   5,  6, 88, 89);
    tbl[16] = mk(0,0,2'b00,   5,  6, 88, 89, 2'b00,0,0,1,   5,  6, 88, 89);
    tbl[17] = mk(0,1,2'b01,2000,900, 88, 89, 2'b00,0,1,1,   5,  6, 88, 89);
    tbl[18] = mk(0,0,2'b00,2000,900, 88, 89, 2'b01,0,1,1,   5,  6, 88, 89);
    tbl[19] = mk(0,0,2'b00,2000,900, 88, 89, 2'b00,1,0,1,  CX, CY, 88, 89);
    tbl[20] = mk(0,1,2'b00,2000,900, 88, 89, 2'b00,0,1,1,  CX, CY, 88, 89);
    tbl[21] = mk(0,0,2'b00,2000,900, 88, 89, 2'b00,1,0,1,  CX, CY, 88, 89);
    tbl[22] = mk(0,1,2'b11,   1,  2,  3,  4, 2'b00,0,1,1,  CX, CY, 88, 89);
    tbl[23] = mk(1,0,2'b00,   1,  2,  3,  4, 2'b00,0,0,0,   0,  0,  0,  0);
    tbl[24] = mk(0,0,2'b00,   1,  2,  3,  4, 2'b00,0,0,0,   0,  0,  0,  0);

    @(negedge clk);
    for (int r = 0; r < 25; r++) begin
      rst = tbl[r].rst; vblank_start = tbl[r].vb; req = tbl[r].req;
      xpos_in = {tbl[r].x1, tbl[r].x0};
      ypos_in = {tbl[r].y1, tbl[r].y0};
      @(posedge clk); #1;
      chk($sformatf("vec%0d ack", r),  32'(ack),          32'(tbl[r].ack));
      chk($sformatf("vec%0d fc", r),   32'(frame_commit), 32'(tbl[r].fc));
      chk($sformatf("vec%0d busy", r), 32'(busy),         32'(tbl[r].busy));
      chk($sformatf("vec%0d ovr", r),  32'(overrun),      32'(tbl[r].ovr));
      chk($sformatf("vec%0d xout", r), 32'(xpos_out),     32'({tbl[r].ox1, tbl[r].ox0}));
      chk($sformatf("vec%0d yout", r), 32'(ypos_out),     32'({tbl[r].oy1, tbl[r].oy0}));
    end

    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      vblank_start = ($urandom_range(0, 4) == 0);
      req = N'($urandom);
      xpos_in = (N*W)'($urandom);
      ypos_in = (N*W)'($urandom);
      model_edge();
      for (int i = 0; i < N; i++) begin
        ex[i*W +: W] = m_ox[i];
        ey[i*W +: W] = m_oy[i];
      end
      @(posedge clk); #1;
      chk("rnd ack",  32'(ack),          32'(e_ack));
      chk("rnd fc",   32'(frame_commit), 32'(e_fc));
      chk("rnd busy", 32'(busy),         32'(m_busy));
      chk("rnd ovr",  32'(overrun),      32'(m_ovr));
      chk("rnd xout", 32'(xpos_out),     32'(ex));
      chk("rnd yout", 32'(ypos_out),     32'(ey));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
